// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and width codes for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [2:0] WIDTH_BYTE = 3'b000;
    localparam logic [2:0] WIDTH_HALF = 3'b001;
    localparam logic [2:0] WIDTH_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    owner_e r_last_grant;

    // Bit 0 is the fetch side, bit 1 the data side; ties go to whoever lost last.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (r_last_grant == OWN_D) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= OWN_D;
        end else if (en && |req) begin
            r_last_grant <= owner_e'(grant[1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-port byte memory between fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    output logic            i_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] i_rsp_data,
    output logic            i_rsp_fault,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [2:0]      d_req_width,
    input  logic            d_req_write,
    output logic            d_rsp_valid,
    input  logic            d_rsp_ready,
    output logic [XLEN-1:0] d_rsp_data,
    output logic            d_rsp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_width,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_valM,
    input  logic            mem_fault
);

    state_e          r_state;
    state_e          w_next_state;
    owner_e          r_owner;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_width;
    logic            r_write;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_fault;
    logic            w_arb_en;
    logic [1:0]      w_grant;
    logic            w_rsp_done;

    // Gating with reset_n keeps the request readies low while reset is held.
    assign w_arb_en = (r_state == IDLE) && reset_n;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (w_arb_en),
        .req     ({d_req_valid, i_req_valid}),
        .grant   (w_grant)
    );

    assign i_req_ready = w_grant[0];
    assign d_req_ready = w_grant[1];

    assign w_rsp_done = (r_owner == OWN_I) ? i_rsp_ready : d_rsp_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_next_state = ISSUE;
            ISSUE:   w_next_state = RESP;
            RESP:    if (w_rsp_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_I;
            r_addr  <= '0;
            r_wdata <= '0;
            r_width <= 3'b000;
            r_write <= 1'b0;
        end else if (w_grant[0]) begin
            r_owner <= OWN_I;
            r_addr  <= i_req_addr;
            r_wdata <= '0;
            r_width <= WIDTH_WORD;
            r_write <= 1'b0;
        end else if (w_grant[1]) begin
            r_owner <= OWN_D;
            r_addr  <= d_req_addr;
            r_wdata <= d_req_wdata;
            r_width <= d_req_width;
            r_write <= d_req_write;
        end
    end

    // Stores return zero data; the fault flag is captured either way.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_data  <= '0;
            r_rsp_fault <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_rsp_data  <= r_write ? '0 : mem_valM;
            r_rsp_fault <= mem_fault;
        end
    end

    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_width    = r_width;
    assign mem_read_en  = (r_state == ISSUE) && !r_write;
    assign mem_write_en = (r_state == ISSUE) && r_write;

    assign i_rsp_valid  = (r_state == RESP) && (r_owner == OWN_I);
    assign d_rsp_valid  = (r_state == RESP) && (r_owner == OWN_D);
    assign i_rsp_data   = r_rsp_data;
    assign i_rsp_fault  = r_rsp_fault;
    assign d_rsp_data   = r_rsp_data;
    assign d_rsp_fault  = r_rsp_fault;

endmodule
`default_nettype wire
